// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states,
// and the step-counter width helper.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_e;

    localparam int MDU_N_DEF     = 32;
    localparam int MDU_CNT_W_DEF = $clog2(MDU_N_DEF);

    function automatic int cnt_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it did not borrow.
module mdu_divstep #(
    parameter int N = 32
) (
    input  logic [N-1:0] rem_i,
    input  logic         bit_i,
    input  logic [N-1:0] dvsr_i,
    output logic [N-1:0] rem_o,
    output logic         q_o
);

    logic [N:0] diff;

    // rem_i < dvsr_i always holds, so the difference never needs more than N+1 bits
    assign diff  = {rem_i, bit_i} - {1'b0, dvsr_i};
    assign q_o   = ~diff[N];
    assign rem_o = q_o ? diff[N-1:0] : {rem_i[N-2:0], bit_i};

endmodule

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO. Define MDU_FAST_MUL_EN to make
// multiplies single-cycle through a combinational multiplier; divides stay iterative.
module mdu
    import mdu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = cnt_w(N);

    mdu_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N:0]   acc_q, acc_d;
    logic [N-1:0]   opb_q, opb_d;
    logic [N-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic           is_div_q, is_div_d;
    logic           negp_q, negp_d, negr_q, negr_d, bz_q, bz_d;
    logic           done_q, done_d;

    logic           sgn;
    logic [N-1:0]   mag_a, mag_b, div_rem;
    logic           div_qb;
    logic [N:0]     mul_sum;
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   quo_fix, rem_fix;

    assign sgn   = (op == MDU_MULT) || (op == MDU_DIV);
    assign mag_a = (sgn && a[N-1]) ? -a : a;
    assign mag_b = (sgn && b[N-1]) ? -b : b;

    // Multiply view of acc: [2N:N] running high half, [N-1:0] remaining multiplier bits.
    // Divide view: [2N-1:N] partial remainder, [N-1:0] dividend shifting out / quotient in.
    assign mul_sum = acc_q[2*N:N] + (acc_q[0] ? {1'b0, opb_q} : '0);

    mdu_divstep #(.N(N)) u_divstep (
        .rem_i  (acc_q[2*N-1:N]),
        .bit_i  (acc_q[N-1]),
        .dvsr_i (opb_q),
        .rem_o  (div_rem),
        .q_o    (div_qb)
    );

    // Divide-by-zero leaves |a| in the remainder, so the remainder sign fix restores a
    assign prod_fix = negp_q ? -acc_q[2*N-1:0] : acc_q[2*N-1:0];
    assign quo_fix  = (negp_q && !bz_q) ? -acc_q[N-1:0] : acc_q[N-1:0];
    assign rem_fix  = negr_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];

`ifdef MDU_FAST_MUL_EN
    logic [2*N-1:0] fa, fb, fast_prod;
    assign fa        = sgn ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
    assign fb        = sgn ? {{N{b[N-1]}}, b} : {{N{1'b0}}, b};
    assign fast_prod = fa * fb;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        negp_d   = negp_q;
        negr_d   = negr_q;
        bz_d     = bz_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CALC;
                    cnt_d    = CW'(N - 1);
                    acc_d    = {{(N+1){1'b0}}, mag_a};
                    opb_d    = mag_b;
                    is_div_d = (op == MDU_DIV) || (op == MDU_DIVU);
                    negp_d   = sgn && (a[N-1] ^ b[N-1]);
                    negr_d   = sgn && a[N-1];
                    bz_d     = (b == '0);
`ifdef MDU_FAST_MUL_EN
                    if (!is_div_d) begin
                        state_d      = S_IDLE;
                        {hi_d, lo_d} = fast_prod;
                        done_d       = 1'b1;
                    end
`endif
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_CALC: begin
                acc_d = is_div_q ? {1'b0, div_rem, acc_q[N-2:0], div_qb}
                                 : {1'b0, mul_sum, acc_q[N-1:1]};
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            negp_q   <= 1'b0;
            negr_q   <= 1'b0;
            bz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            negp_q   <= negp_d;
            negr_q   <= negr_d;
            bz_q     <= bz_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu at N=8: directed table, multi-cycle corner sequences,
// and randomized operations against an arithmetic reference model.
module tb_mdu;
    localparam int N = 8;
`ifdef MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, start, hi_we, lo_we, busy, done;
    logic [1:0]   op;
    logic [N-1:0] a, b, wdata, hi, lo;
    logic [N-1:0] m_hi, m_lo;
    int           n_cmp = 0;
    int           n_fail = 0;

    typedef struct {
        logic [1:0]   op;
        logic [N-1:0] a, b, ehi, elo;
        string        nm;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    mdu #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    // Architectural result from plain integer arithmetic (SV / and % truncate toward zero)
    function automatic logic [2*N-1:0] model(input logic [1:0] o, input logic [N-1:0] x, y);
        longint sx, sy, ux, uy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        case (o)
            2'd0: begin p = sx * sy; return p[2*N-1:0]; end
            2'd1: begin p = ux * uy; return p[2*N-1:0]; end
            default: begin
                if (y == '0) return {x, {N{1'b1}}};
                if (o == 2'd2) begin q = sx / sy; r = sx % sy; end
                else           begin q = ux / uy; r = ux % uy; end
                return {r[N-1:0], q[N-1:0]};
            end
        endcase
    endfunction

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle and follow it to its done cycle
    task automatic run_op(input logic [1:0] o, input logic [N-1:0] x, y,
                          input logic [2*N-1:0] e, input string nm);
        int lat;
        lat = (FAST && !o[1]) ? 1 : N + 2;
        op = o; a = x; b = y; start = 1'b1;
        step();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        a = N'($urandom); b = N'($urandom); op = 2'($urandom);
        for (int c = 1; c < lat; c++) begin
            chk_b({nm, " busy"}, busy, 1'b1);
            chk_b({nm, " early done"}, done, 1'b0);
            chk_w({nm, " hold"}, {hi, lo}, {m_hi, m_lo});
            step();
        end
        chk_b({nm, " done"}, done, 1'b1);
        chk_b({nm, " idle"}, busy, 1'b0);
        chk_w({nm, " hi:lo"}, {hi, lo}, e);
        {m_hi, m_lo} = e;
    endtask

    initial begin
        tbl[0] = '{2'd0, 8'hFD, 8'h05, 8'hFF, 8'hF1, "mult -3*5"};
        tbl[1] = '{2'd1, 8'hFD, 8'h05, 8'h04, 8'hF1, "multu 253*5"};
        tbl[2] = '{2'd2, 8'hF9, 8'h02, 8'hFF, 8'hFD, "div -7/2"};
        tbl[3] = '{2'd3, 8'd200, 8'd7, 8'h04, 8'h1C, "divu 200/7"};
        tbl[4] = '{2'd2, 8'h2A, 8'h00, 8'h2A, 8'hFF, "div by zero"};
        tbl[5] = '{2'd2, 8'h80, 8'hFF, 8'h00, 8'h80, "div overflow"};

        reset = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = '0; a = '0; b = '0; wdata = '0;
        #1;
        chk_b("reset busy", busy, 1'b0);
        chk_b("reset done", done, 1'b0);
        chk_w("reset hi:lo", {hi, lo}, '0);
        step(); step();
        reset = 1'b1;
        m_hi = '0; m_lo = '0;

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].ehi, tbl[i].elo}, tbl[i].nm);
            step();
            chk_b({tbl[i].nm, " done width"}, done, 1'b0);
            chk_b({tbl[i].nm, " stays idle"}, busy, 1'b0);
        end

        // start and hi_we while busy are both ignored
        op = 2'd3; a = 8'd200; b = 8'd7; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        start = 1'b1; op = 2'd0; a = 8'h11; b = 8'h22; hi_we = 1'b1; wdata = 8'hAA;
        step();
        start = 1'b0; hi_we = 1'b0;
        chk_b("busy ign busy", busy, 1'b1);
        chk_w("busy ign hold", {hi, lo}, {m_hi, m_lo});
        repeat (4) step();
        chk_b("busy ign done", done, 1'b1);
        chk_w("busy ign hi:lo", {hi, lo}, 16'h041C);
        m_hi = 8'h04; m_lo = 8'h1C;
        step();
        chk_b("busy ign no relaunch", busy, 1'b0);
        chk_w("busy ign held", {hi, lo}, 16'h041C);

        // MTHI in idle
        hi_we = 1'b1; wdata = 8'h55;
        step();
        hi_we = 1'b0;
        chk_w("mthi idle", {hi, lo}, {8'h55, m_lo});
        m_hi = 8'h55;

        // start wins over a same-cycle MTLO
        lo_we = 1'b1; wdata = 8'h99;
        run_op(2'd3, 8'd100, 8'd9, model(2'd3, 8'd100, 8'd9), "start beats mtlo");

        // back-to-back: second start in the done cycle
        run_op(2'd2, 8'h80, 8'h03, model(2'd2, 8'h80, 8'h03), "b2b first");
        run_op(2'd0, 8'h80, 8'h80, model(2'd0, 8'h80, 8'h80), "b2b second");

        // asynchronous reset mid-multiply
        step();
        op = 2'd0; a = 8'hFD; b = 8'h05; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk_b("midreset busy", busy, 1'b0);
        chk_b("midreset done", done, 1'b0);
        chk_w("midreset hi:lo", {hi, lo}, '0);
        step();
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        run_op(2'd1, 8'd3, 8'd4, 16'h000C, "after reset multu");

        for (int i = 0; i < 40; i++) begin
            logic [1:0]   ro;
            logic [N-1:0] ra, rb;
            int           gap;
            ro = 2'($urandom);
            ra = N'($urandom);
            rb = N'($urandom);
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 8'h80; rb = 8'hFF; end
                default: ;
            endcase
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                hi_we = 1'($urandom); lo_we = 1'($urandom); wdata = N'($urandom);
                step();
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
                hi_we = 1'b0; lo_we = 1'b0;
                chk_w("rand mthi/mtlo", {hi, lo}, {m_hi, m_lo});
            end
            run_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rand%0d op%0d %h,%h", i, ro, ra, rb));
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the MIPS core, sitting beside the `Alu` in the datapath and holding the architectural HI/LO registers. It executes MULT, MULTU, DIV and DIVU over a parametrised operand width using a shift-add / restoring-division state machine. It also supports direct HI/LO writes for MTHI/MTLO. The controller issues a start pulse, stalls on `busy`, and reads `hi`/`lo` for MFHI/MFLO.

## Interface
- `N`, default 32: operand width. Legal range 4..64. HI and LO are each `N` bits wide.
- `clk` input, 1 bit: clock, rising edge active.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: launch the operation selected by `op`. Sampled only in IDLE.
- `op` input, 2 bits: 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU.
- `a`, `b` input, `N` bits: operands (rs, rt). Sampled on the accepting edge only.
- `hi_we`, `lo_we` input, 1 bit each: MTHI/MTLO write enables.
- `wdata` input, `N` bits: data for MTHI/MTLO writes.
- `busy` output, 1 bit: an operation is in flight.
- `done` output, 1 bit: one-cycle pulse marking that `hi`/`lo` now hold the result.
- `hi`, `lo` output, `N` bits each: the HI and LO registers.

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE:**
  - `start`=1 latches `op`, `a`, `b` and enters CALC.
  - The step counter loads `N-1`.
  - For signed ops, operands are converted to magnitudes and the result signs are recorded.
- **CALC:**
  - MUL: one partial product bit per cycle, shift-add into a 2N-bit accumulator.
  - DIV: one restoring step per cycle (shift the remainder, trial-subtract, set a quotient bit).
  - When the counter reaches 0, go to FIX. Otherwise decrement.
- **FIX:**
  - Apply sign correction.
    - MULT: negate the 2N product if the operand signs differ.
    - DIV: negate the quotient if the signs differ; the remainder takes the sign of `a`.
  - Write HI/LO, pulse `done`, return to IDLE.
- **Results:**
  - MUL: `{hi,lo}` = 2N-bit product.
  - DIV: `lo` = quotient, `hi` = remainder (truncating toward zero).
- **Divide by zero** (DIV or DIVU with `b`=0): `lo` = all ones, `hi` = `a`. The sign fix is bypassed. Timing is the same as a normal divide.
- **Signed overflow** (most-negative / -1): `lo` = most-negative, `hi` = 0. No trap.
- **`start` while busy:** ignored.
- **`hi_we`/`lo_we`:**
  - In IDLE, they write `wdata` at the next edge.
  - While busy, they are ignored.
  - In IDLE with `start` also high, `start` wins and the write is dropped.
- **Reset** (at any time, including mid-operation):
  - State goes to IDLE and the counter clears.
  - `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0.

## Timing
- Cycle 0: `start` is high in IDLE and is accepted on the closing edge.
- Cycles 1..N: CALC, `busy`=1.
- Cycle N+1: FIX, `busy`=1.
- Cycle N+2: `busy`=0, `done`=1, `hi`/`lo` hold the result. Total latency is N+2 cycles.
- Back-to-back: `start` in the `done` cycle is accepted. Throughput is one operation per N+2 cycles.
- `hi`/`lo` change only on the FIX-exit edge or on an accepted MTHI/MTLO edge. They are stable throughout CALC.
- `done` is registered and high for exactly one cycle.

## Configuration
- **`MDU_FAST_MUL_EN`:**
  - Defined: MULT/MULTU use a single-cycle combinational N×N multiplier.
    - The accepting edge writes `{hi,lo}`.
    - `done`=1 in cycle 1 and `busy` never asserts.
    - DIV/DIVU are unchanged.
  - Undefined: all operations are iterative with N+2 latency, and no hardware multiplier is inferred.

## Structure
- **`mdu_pkg`** holds:
  - `op` encodings: `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`.
  - The state enum: `S_IDLE`, `S_CALC`, `S_FIX`.
  - The counter width `$clog2(N)`.
- **Sub-module `mdu_divstep`:** one combinational restoring-division step.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated once per cycle inside CALC.

## Test plan (N=8; iterative results are checked 10 cycles after `start`)
- MULT `a`=8'hFD, `b`=8'h05 → `hi`=8'hFF, `lo`=8'hF1, `done` pulses once in cycle 10.
- MULTU `a`=8'hFD, `b`=8'h05 → `hi`=8'h04, `lo`=8'hF1.
- DIV `a`=8'hF9 (-7), `b`=8'h02 → `lo`=8'hFD, `hi`=8'hFF. DIVU `a`=200, `b`=7 → `lo`=8'h1C, `hi`=8'h04.
- DIV `a`=8'h2A, `b`=0 → `lo`=8'hFF, `hi`=8'h2A. DIV `a`=8'h80, `b`=8'hFF → `lo`=8'h80, `hi`=8'h00.
- `start` and `hi_we` pulsed in cycle 5 of a DIVU 200/7 → both ignored, result still 8'h1C/8'h04. Then `hi_we` with `wdata`=8'h55 in IDLE → `hi`=8'h55.
- `reset` low in cycle 4 of a MULT → `busy`=0, `hi`=`lo`=0 immediately. A new MULTU 3×4 after release → `lo`=8'h0C, `hi`=0 at N+2.
